// File: rtl/pc_fetch_redirect_pkg.sv
// Shared types and defaults for the PC / fetch front end.
// Holds fetch FSM encodings and default PC reset/step values.
package pc_fetch_redirect_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_fetch_redirect_skid.sv
// One-entry holding register for a fetch completed under stall.
// Ports: clk, rst, i_load/i_clear, i_instr/i_pc in; o_valid/o_instr/o_pc out.
module pc_fetch_redirect_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pc_fetch_redirect.sv
// PC + instruction fetch front end with redirect, stale-drop and stall hold.
// Ports: clk, rst, pc_src/target_pc, stall_in, imem_* handshake, if_*, flush.
module pc_fetch_redirect
  import pc_fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] target_pc,
  input  logic        stall_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;

  logic [31:0]  w_tgt;
  logic         w_skid_load;
  logic         w_skid_clr;
  logic         w_skid_valid;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pc;

  assign w_tgt = word_align(target_pc);

  assign w_skid_load = (r_state == S_REQ) & imem_ready
                     & ~pc_src & stall_in;
  assign w_skid_clr  = (r_state == S_HOLD)
                     & (pc_src | ~stall_in);

  pc_fetch_redirect_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clr),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_pending  <= '0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            if (pc_src) begin
              r_pc       <= w_tgt;
              r_if_valid <= 1'b0;
            end else if (stall_in) begin
              r_state <= S_HOLD;
            end else begin
              r_if_valid <= 1'b1;
              r_if_instr <= imem_rdata;
              r_if_pc    <= r_pc;
              r_pc       <= r_pc + PC_STEP;
            end
          end else if (pc_src) begin
            // Old address must stay on the bus until it completes.
            r_pending  <= w_tgt;
            r_if_valid <= 1'b0;
            r_state    <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (pc_src) begin
            r_pc       <= w_tgt;
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
          end else if (!stall_in) begin
            r_if_valid <= w_skid_valid;
            r_if_instr <= w_skid_instr;
            r_if_pc    <= w_skid_pc;
            r_pc       <= r_pc + PC_STEP;
            r_state    <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (pc_src) begin
            r_if_valid <= 1'b0;
          end
          if (imem_ready) begin
            // Newest redirect wins over the pending one.
            r_pc    <= pc_src ? w_tgt : r_pending;
            r_state <= S_REQ;
          end else if (pc_src) begin
            r_pending <= w_tgt;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req  = ~rst & (r_state != S_HOLD);
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign flush     = pc_src;

endmodule
